// File: rtl/imdct_ola.sv
// Overlap-add stage behind the IMDCT RAM wrapper: reads 2N results per frame, emits N saturated samples, keeps the upper half as history.
// First sample_vld 3 cycles after done; backpressure stalls only first-half reads, bounded by an OBUF_DEPTH read credit.

module ram512x32 (
    input  logic        clk,
    input  logic        we,
    input  logic [8:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [8:0]  raddr,
    output logic [31:0] rdata
);
    logic [31:0] mem [512];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

module imdct_ola #(
    parameter int DW         = 32,
    parameter int OBUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          done,
    input  logic          tabidx,
    input  logic [DW-1:0] imdct_dout,
    output logic [9:0]    rd_addr,
    output logic          busy,
    input  logic          flush,
    output logic [DW-1:0] sample,
    output logic          sample_vld,
    input  logic          sample_rdy,
    output logic          frame_end,
    output logic          overrun
);
    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CW = $clog2(OBUF_DEPTH + 1);
    localparam int OW = CW + 1;

    typedef enum logic [1:0] {IDLE, PH_A, PH_B, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [8:0]    idx_q, idx_d;
    logic          tab_q, tab_d;
    logic          use_hist_q, use_hist_d;
    logic          hist_vld_q, hist_tab_q;
    logic          rdv_q, wrv_q;
    logic [8:0]    wr_addr_q;
    logic          overrun_q;
    logic [DW-1:0] obuf_q [OBUF_DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;

    logic          issue_a, issue_b, last, pop, credit_ok;
    logic [OW-1:0] occ;
    logic [DW-1:0] hist_dout, hadd, sum_sat;
    logic [DW:0]   sum;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign busy       = (state_q != IDLE);
    assign sample_vld = (cnt_q != '0);
    assign sample     = obuf_q[rp_q];
    assign overrun    = overrun_q;
    assign pop        = sample_vld & sample_rdy;
    assign last       = (idx_q == (tab_q ? 9'd511 : 9'd63));

    // A sample leaving this cycle frees its slot, so full-rate streaming never stalls.
    assign occ       = {1'b0, cnt_q} + OW'(rdv_q) - OW'(pop);
    assign credit_ok = (occ < OW'(OBUF_DEPTH));

    ram512x32 u_hist (
        .clk   (clk),
        .we    (wrv_q),
        .waddr (wr_addr_q),
        .wdata (imdct_dout),
        .raddr (idx_q),
        .rdata (hist_dout)
    );

    always_comb begin
        hadd = use_hist_q ? hist_dout : '0;
        sum  = {imdct_dout[DW-1], imdct_dout} + {hadd[DW-1], hadd};
        if (sum[DW] != sum[DW-1])
            sum_sat = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            sum_sat = sum[DW-1:0];
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tab_d      = tab_q;
        use_hist_d = use_hist_q;
        rd_addr    = '0;
        issue_a    = 1'b0;
        issue_b    = 1'b0;
        frame_end  = 1'b0;
        case (state_q)
            IDLE: begin
                if (done) begin
                    tab_d      = tabidx;
                    use_hist_d = hist_vld_q & ~flush & (hist_tab_q == tabidx);
                    idx_d      = '0;
                    state_d    = PH_A;
                end
            end
            PH_A: begin
                rd_addr = {1'b0, idx_q};
                if (credit_ok) begin
                    issue_a = 1'b1;
                    idx_d   = last ? '0 : idx_q + 9'd1;
                    if (last) state_d = PH_B;
                end
            end
            PH_B: begin
                // Index restarts at 0 so the DRAIN-cycle read never hits the final write address.
                rd_addr = (tab_q ? 10'd512 : 10'd64) + {1'b0, idx_q};
                issue_b = 1'b1;
                idx_d   = last ? '0 : idx_q + 9'd1;
                if (last) state_d = DRAIN;
            end
            DRAIN: begin
                frame_end = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            tab_q      <= 1'b0;
            use_hist_q <= 1'b0;
            hist_vld_q <= 1'b0;
            hist_tab_q <= 1'b0;
            rdv_q      <= 1'b0;
            wrv_q      <= 1'b0;
            wr_addr_q  <= '0;
            overrun_q  <= 1'b0;
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            for (int k = 0; k < OBUF_DEPTH; k++) obuf_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tab_q      <= tab_d;
            use_hist_q <= use_hist_d;
            rdv_q      <= issue_a;
            wrv_q      <= issue_b;
            wr_addr_q  <= idx_q;
            overrun_q  <= done & busy;
            if (state_q == DRAIN) begin
                hist_vld_q <= 1'b1;
                hist_tab_q <= tab_q;
            end else if (state_q == IDLE && flush) begin
                hist_vld_q <= 1'b0;
            end
            if (rdv_q) begin
                obuf_q[wp_q] <= sum_sat;
                wp_q         <= ptr_inc(wp_q);
            end
            if (pop) rp_q <= ptr_inc(rp_q);
            cnt_q <= cnt_q + CW'(rdv_q) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_imdct_ola.sv
// Bench for imdct_ola: upstream RAM model, reference overlap-add model feeding an expected-sample queue.
module tb_imdct_ola;
    logic        clk = 1'b0;
    logic        rst_n, done, tabidx, flush, sample_rdy;
    logic [31:0] imdct_dout, sample;
    logic [9:0]  rd_addr;
    logic        busy, sample_vld, frame_end, overrun;

    always #5 clk = ~clk;

    imdct_ola #(.DW(32), .OBUF_DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .done       (done),
        .tabidx     (tabidx),
        .imdct_dout (imdct_dout),
        .rd_addr    (rd_addr),
        .busy       (busy),
        .flush      (flush),
        .sample     (sample),
        .sample_vld (sample_vld),
        .sample_rdy (sample_rdy),
        .frame_end  (frame_end),
        .overrun    (overrun)
    );

    logic [31:0] imdct_mem [1024];
    always @(posedge clk) imdct_dout <= imdct_mem[rd_addr];

    logic [31:0] m_hist [512];
    bit          m_hist_vld, m_hist_tab;
    logic [31:0] exp_q [$];
    int          n_cmp, n_err, cyc, t0, cur_n, acc, max_lead, stab_err;
    int          fv, fe, bl, addr1, addr_b, ovr_cnt;
    bit          rdy_rand, prev_stall;
    logic [31:0] prev_sample;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > MAXV) return 32'h7FFFFFFF;
        if (s < MINV) return 32'h80000000;
        return s[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit d, input bit fl);
        int lead;
        @(negedge clk);
        done       = d;
        flush      = fl;
        sample_rdy = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
        #1;
        cyc++;
        lead = int'(rd_addr) - acc;
        if (busy && int'(rd_addr) < cur_n && lead > max_lead) max_lead = lead;
        if (prev_stall && (!sample_vld || sample !== prev_sample)) stab_err++;
        prev_stall  = sample_vld && !sample_rdy;
        prev_sample = sample;
        if (sample_vld && sample_rdy) begin
            acc++;
            if (exp_q.size() == 0) chk("extra_sample", 32'(sample_vld), 32'd0);
            else chk("sample", sample, exp_q.pop_front());
        end
        if (cyc - t0 == 1) addr1 = int'(rd_addr);
        if (cyc - t0 == cur_n + 1) addr_b = int'(rd_addr);
        if (sample_vld && fv < 0) fv = cyc - t0;
        if (frame_end && fe < 0) fe = cyc - t0;
        if (!busy && bl < 0 && cyc - t0 > 0) bl = cyc - t0;
        if (overrun) ovr_cnt++;
    endtask

    task automatic start_frame(input bit tab);
        int n;
        bit uh;
        n     = tab ? 512 : 64;
        uh    = m_hist_vld && (m_hist_tab == tab);
        cur_n = n;
        tabidx = tab;
        for (int i = 0; i < n; i++) exp_q.push_back(sat_add(imdct_mem[i], uh ? m_hist[i] : 32'h0));
        t0 = cyc + 1;
        acc = 0; max_lead = 0; stab_err = 0; ovr_cnt = 0;
        fv = -1; fe = -1; bl = -1; addr1 = -1; addr_b = -1;
        step(1'b1, 1'b0);
    endtask

    task automatic finish_frame(input bit tab, input int ovr_at, input bit timing);
        int n;
        bit ok;
        n  = tab ? 512 : 64;
        ok = 1'b0;
        for (int k = 1; k < 6000; k++) begin
            if (fe >= 0 && bl >= 0 && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            step(k == ovr_at, 1'b0);
        end
        chk("frame_done", 32'(ok), 32'd1);
        chk("lead_le_2", 32'(max_lead <= 2), 32'd1);
        chk("stable_stall", stab_err, 0);
        chk("overrun_cnt", ovr_cnt, (ovr_at > 0) ? 1 : 0);
        if (timing) begin
            chk("first_vld_cyc", fv, 3);
            chk("frame_end_cyc", fe, 2 * n + 1);
            chk("busy_low_cyc", bl, 2 * n + 2);
            chk("rd_addr_a0", addr1, 0);
            chk("rd_addr_b0", addr_b, n);
        end
        for (int i = 0; i < n; i++) m_hist[i] = imdct_mem[n + i];
        m_hist_vld = 1'b1;
        m_hist_tab = tab;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_sample"}, sample, 32'd0);
        chk({pfx, "_sample_vld"}, 32'(sample_vld), 32'd0);
        chk({pfx, "_frame_end"}, 32'(frame_end), 32'd0);
        chk({pfx, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; t0 = 0; cur_n = 0; acc = 0;
        rst_n = 1'b0; done = 1'b0; flush = 1'b0; tabidx = 1'b0; sample_rdy = 1'b1;
        rdy_rand = 1'b0; prev_stall = 1'b0; prev_sample = '0;
        m_hist_vld = 1'b0; m_hist_tab = 1'b0;
        for (int k = 0; k < 1024; k++) imdct_mem[k] = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // Frame 1: ramp, no history, full-rate timing
        for (int k = 0; k < 1024; k++) imdct_mem[k] = 32'(k);
        start_frame(1'b1);
        finish_frame(1'b1, 0, 1'b1);

        // Frame 2: history from frame 1 upper half
        for (int k = 0; k < 1024; k++) imdct_mem[k] = 32'(1000 + k);
        start_frame(1'b1);
        finish_frame(1'b1, 0, 1'b1);

        // Frame 3: same data under random 30% ready
        rdy_rand = 1'b1;
        start_frame(1'b1);
        finish_frame(1'b1, 0, 1'b0);
        rdy_rand = 1'b0;

        // Frame 4: switch to short table, history must be ignored
        for (int k = 0; k < 128; k++) imdct_mem[k] = 32'(5000 - 3 * k);
        start_frame(1'b0);
        finish_frame(1'b0, 0, 1'b1);

        // Frame 5: flush in idle drops the short-table history
        step(1'b0, 1'b1);
        m_hist_vld = 1'b0;
        for (int k = 0; k < 128; k++) imdct_mem[k] = 32'(11 * k);
        start_frame(1'b0);
        finish_frame(1'b0, 0, 1'b0);

        // Frames 6-8: positive then negative saturation
        for (int k = 0; k < 128; k++) imdct_mem[k] = (k < 64) ? 32'h0 : 32'h7FFFFFF0;
        start_frame(1'b0);
        finish_frame(1'b0, 0, 1'b0);
        for (int k = 0; k < 128; k++) imdct_mem[k] = (k < 64) ? 32'h100 : 32'h80000010;
        start_frame(1'b0);
        finish_frame(1'b0, 0, 1'b0);
        for (int k = 0; k < 128; k++) imdct_mem[k] = (k < 64) ? 32'hFFFFFF00 : 32'h0;
        start_frame(1'b0);
        finish_frame(1'b0, 0, 1'b0);

        // Frame 9: done while busy at cycle 100
        for (int k = 0; k < 1024; k++) imdct_mem[k] = 32'(3 * k + 1);
        start_frame(1'b1);
        finish_frame(1'b1, 100, 1'b1);

        // Reset mid-frame at cycle 300, then a frame with no history
        for (int k = 0; k < 1024; k++) imdct_mem[k] = 32'(k + 77);
        start_frame(1'b1);
        repeat (299) step(1'b0, 1'b0);
        chk("busy_mid_frame", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        exp_q.delete();
        m_hist_vld = 1'b0;
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 1024; k++) imdct_mem[k] = 32'(5 * k + 3);
        start_frame(1'b1);
        finish_frame(1'b1, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
